odd_seq_gen: RTL and testbench

Parametrised odd-number sequence generator with a streaming output. A start pulse latches a seed and a limit. The block rounds the seed up to the nearest odd value, then emits successive odd values (step 2) below the limit over a valid/ready interface. It runs either once or in a continuous wrap-around mode, and sits between control logic and any downstream consumer of odd-value streams.

---
 rtl/odd_pkg.sv | 15 +
 rtl/odd_round.sv | 25 ++
 rtl/odd_seq_gen.sv | 130 +++++++++++++
 tb/tb_odd_seq_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/odd_pkg.sv
// Shared definitions for the odd-number sequence generator.
//   state_e      : controller states (IDLE, RUN)
//   MODE_ONESHOT : stop after the last value below the limit
//   MODE_WRAP    : restart from the first value after the last one
package odd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_WRAP    = 1'b1;

endpackage

// File: rtl/odd_round.sv
// Combinational odd-value helper.
//   value   : input operand
//   rounded : value rounded up to odd (value | 1)
//   next    : value + 2, truncated to WIDTH bits
//   carry   : set when value + 2 does not fit in WIDTH bits
module odd_round #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] rounded,
    output logic [WIDTH-1:0] next,
    output logic             carry
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH:0]   TWO = (WIDTH + 1)'(2);

    logic [WIDTH:0] sum;

    assign rounded = value | ONE;
    assign sum     = {1'b0, value} + TWO;
    assign next    = sum[WIDTH-1:0];
    assign carry   = sum[WIDTH];

endmodule

// File: rtl/odd_seq_gen.sv
// Odd-number sequence generator with a valid/ready output stream.
//   clk, rst_n           : clock, synchronous active-low reset
//   start, mode, stop    : run control (start/mode sampled in IDLE, stop in RUN)
//   seed, limit          : first value (rounded up to odd) and exclusive bound
//   out_valid, out_ready : output handshake
//   out_data             : current odd value
//   busy, done           : run in progress, one-cycle end-of-run pulse
//   count                : values accepted in current/last run, saturating
module odd_seq_gen
    import odd_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             stop,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] limit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] first_q, first_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;

    // One helper serves both uses: in IDLE it rounds the seed, in RUN it
    // steps the current value.
    logic [WIDTH-1:0] round_in;
    logic [WIDTH-1:0] round_odd;
    logic [WIDTH-1:0] round_next;
    logic             round_carry;

    assign round_in = (state_q == IDLE) ? seed : data_q;

    odd_round #(
        .WIDTH (WIDTH)
    ) u_round (
        .value   (round_in),
        .rounded (round_odd),
        .next    (round_next),
        .carry   (round_carry)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        first_d = first_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        count_d = count_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    limit_d = limit;
                    first_d = round_odd;
                    count_d = '0;
                    if (round_odd < limit) begin
                        state_d = RUN;
                        data_d  = round_odd;
                    end else begin
                        // Empty range: nothing to emit, end immediately.
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // out_valid is always high in RUN, so out_ready is the handshake.
                if (out_ready && (count_q != '1)) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (out_ready) begin
                    if (!round_carry && (round_next < limit_q)) begin
                        data_d = round_next;
                    end else if (mode_q == MODE_WRAP) begin
                        data_d = first_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            first_q <= '0;
            limit_q <= '0;
            mode_q  <= MODE_ONESHOT;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            first_q <= first_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign out_data  = data_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_odd_seq_gen.sv
// Self-checking bench for odd_seq_gen: directed scenarios plus randomized
// runs, compared cycle by cycle against a list-based reference model.
module tb_odd_seq_gen;

    localparam int W       = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic          stop;
    logic [W-1:0]  seed;
    logic [W-1:0]  limit;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    odd_seq_gen #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .stop      (stop),
        .seed      (seed),
        .limit     (limit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a run is the list of odd values in [seed|1, limit),
    // walked one entry per accepted handshake.
    int m_vals[$];
    int m_idx   = 0;
    bit m_run   = 1'b0;
    bit m_done  = 1'b0;
    bit m_wrap  = 1'b0;
    int m_count = 0;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            m_run   = 1'b0;
            m_done  = 1'b0;
            m_count = 0;
            m_idx   = 0;
            m_vals  = {};
        end else if (!m_run) begin
            m_done = 1'b0;
            if (start) begin
                m_vals = {};
                for (int v = int'(seed) | 1; v < int'(limit); v += 2) m_vals.push_back(v);
                m_wrap  = mode;
                m_count = 0;
                m_idx   = 0;
                if (m_vals.size() > 0) m_run = 1'b1;
                else                   m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (out_ready) m_count = (m_count == CNT_MAX) ? CNT_MAX : m_count + 1;
            if (stop) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else if (out_ready) begin
                m_idx++;
                if (m_idx == m_vals.size()) begin
                    if (m_wrap) begin
                        m_idx = 0;
                    end else begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("out_valid", 32'(out_valid), 32'(m_run));
            check_eq("busy", 32'(busy), 32'(m_run));
            check_eq("done", 32'(done), 32'(m_done));
            check_eq("count", 32'(count), 32'(m_count));
            if (m_run) check_eq("out_data", 32'(out_data), 32'(m_vals[m_idx]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int s, input int l, input bit m);
        seed  = W'(s);
        limit = W'(l);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        // Scramble the sampled inputs: they must not matter after start.
        seed  = W'($urandom);
        limit = W'($urandom);
        mode  = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget, input bit rand_ready);
        int n = 0;
        while (m_run && n < budget) begin
            out_ready = rand_ready ? 1'($urandom) : 1'b1;
            step();
            n++;
        end
        check_eq("wait_idle_timeout", 32'(m_run), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        stop      = 1'b0;
        seed      = '0;
        limit     = '0;
        out_ready = 1'b0;
        repeat (3) step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        check_eq("reset_data", 32'(out_data), 32'd0);
        check_eq("reset_count", 32'(count), 32'd0);
        step();

        // 3,5,7,9 back to back
        out_ready = 1'b1;
        do_start(2, 10, 1'b0);
        check_eq("first_val_2_10", 32'(out_data), 32'd3);
        wait_idle(50, 1'b0);
        check_eq("done_2_10", 32'(done), 32'd1);
        check_eq("count_2_10", 32'(count), 32'd4);
        step();

        // single value 9
        do_start(9, 10, 1'b0);
        wait_idle(50, 1'b0);
        check_eq("count_9_10", 32'(count), 32'd1);
        step();

        // empty ranges: done on the cycle after start is sampled, nothing emitted
        do_start(10, 10, 1'b0);
        check_eq("empty_done", 32'(done), 32'd1);
        check_eq("empty_valid", 32'(out_valid), 32'd0);
        check_eq("empty_count", 32'(count), 32'd0);
        step();
        check_eq("empty_done_gone", 32'(done), 32'd0);
        do_start(14, 15, 1'b0);
        check_eq("empty_14_15_done", 32'(done), 32'd1);
        check_eq("empty_14_15_valid", 32'(out_valid), 32'd0);
        step();

        // last value below limit ends the one-shot run
        do_start(12, 15, 1'b0);
        wait_idle(50, 1'b0);
        check_eq("count_12_15", 32'(count), 32'd1);
        step();

        // wrap mode with stalls, stop on a handshake of value 3
        do_start(1, 6, 1'b1);
        for (int i = 0; i < 12; i++) begin
            out_ready = 1'(i % 2);
            step();
        end
        begin
            int n = 0;
            while (!(out_valid && out_data == W'(3)) && n < 20) begin
                out_ready = 1'b0;
                step();
                n++;
            end
        end
        out_ready = 1'b1;
        stop      = 1'b1;
        step();
        stop = 1'b0;
        check_eq("stop_valid", 32'(out_valid), 32'd0);
        check_eq("stop_done", 32'(done), 32'd1);
        step();

        // stop in IDLE is ignored
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("idle_stop_done", 32'(done), 32'd0);

        // mid-run reset: reset values, no done pulse
        out_ready = 1'b1;
        do_start(1, 15, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_data", 32'(out_data), 32'd0);
        step();

        // start during RUN is ignored
        out_ready = 1'b1;
        do_start(3, 13, 1'b0);
        seed  = W'(0);
        limit = W'(15);
        mode  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(50, 1'b1);
        check_eq("count_start_in_run", 32'(count), 32'd5);
        step();

        // counter saturation in a long wrap run
        out_ready = 1'b1;
        do_start(1, 4, 1'b1);
        repeat (300) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("count_saturated", 32'(count), 32'(CNT_MAX));
        step();

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            do_start($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
            for (int c = 0; c < 60 && m_run; c++) begin
                out_ready = 1'($urandom);
                stop      = ($urandom_range(0, 19) == 0);
                start     = ($urandom_range(0, 7) == 0);
                step();
            end
            stop  = 1'b0;
            start = 1'b0;
            if (m_run) begin
                stop = 1'b1;
                step();
                stop = 1'b0;
            end
            check_eq("rand_run_ended", 32'(busy), 32'd0);
            repeat ($urandom_range(0, 2)) step();
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
